mem_line_master: RTL
====================

# mem_line_master

Initiator side of the 128-bit line-transfer protocol spoken by the slow memory model. Sits between a cache controller (I- or D-cache) and one slow memory port. It turns a single cache-side miss request (optional dirty writeback plus optional line fill) into correctly sequenced `mem_write`/`mem_read` transactions, holding each until `mem_ready`. It returns the filled line with a one-cycle response pulse.

## Interface
- `TIMEOUT`, default 1023: max cycles to wait for `mem_ready` per transaction; used only when the timeout feature is compiled in.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: cache requests a miss service.
- `req_ready` out 1: high only in IDLE; request accepted when `req_valid && req_ready`.
- `req_wb` in 1: a writeback of a dirty victim is required.
- `req_fill` in 1: a line fill is required.
- `req_wb_addr` in 28: victim line address [31:4].
- `req_fill_addr` in 28: fill line address [31:4].
- `req_wdata` in 128: victim line data.
- `resp_valid` out 1: one-cycle pulse; operation complete.
- `resp_rdata` out 128: fill data; valid with `resp_valid` and held until the next fill completes.
- `resp_err` out 1: qualifies `resp_valid`; operation aborted by timeout.
- `mem_read` out 1: read strobe to slow memory.
- `mem_write` out 1: write strobe to slow memory.
- `mem_addr` out 28: line address [31:4].
- `mem_wdata` out 128: write line data.
- `mem_rdata` in 128: read line data, valid when `mem_ready`.
- `mem_ready` in 1: transaction done; single-cycle pulse from the memory.

## Operation
- Request fields (`req_wb`, `req_fill`, addresses, `req_wdata`) are captured into registers on acceptance. Inputs are don't-care afterwards.
- FSM states: IDLE, WB, GAP, FILL, DONE.
- IDLE, on accept:
  - `req_wb`=1: go to WB.
  - else `req_fill`=1: go to FILL.
  - else: go to DONE (no memory traffic).
- WB:
  - `mem_write`=1, `mem_addr`=wb_addr, `mem_wdata`=captured data, held constant.
  - On `mem_ready`: go to GAP if fill pending, else DONE.
- GAP: all memory strobes low for exactly one cycle, then FILL. This guarantees the memory sees the strobe drop between back-to-back transactions.
- FILL:
  - `mem_read`=1, `mem_addr`=fill_addr.
  - On `mem_ready`: capture `mem_rdata` into `resp_rdata`, go to DONE.
- DONE: `resp_valid`=1 for one cycle, then IDLE.
- `mem_read` and `mem_write` are never high together. Both are low outside WB/FILL.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- `mem_ready` while not in WB/FILL is ignored.

## Timing
- Reset values:
  - state IDLE; `req_ready`=1.
  - `mem_read`=`mem_write`=0; `mem_addr`=0; `mem_wdata`=0.
  - `resp_valid`=0; `resp_rdata`=0; `resp_err`=0.
- Accept at edge T:
  - strobe high from T+1.
  - `mem_ready` sampled at edge R: strobe low from R+1.
- Fill-only: `resp_valid` at R+1, coincident with the strobe dropping.
- WB+fill: GAP occupies cycle R1+1, `mem_read` rises at R1+2.
- No-op request (wb=0, fill=0): `resp_valid` at T+1, `req_ready` back at T+2.
- `req_ready` low from T+1 through the DONE cycle. The next request is accepted no earlier than the cycle after DONE.
- `rst_n` asserted mid-transaction: outputs drop to reset values immediately (asynchronous). No response is issued for the aborted request.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 11-bit wait counter clears on entry to WB/FILL and increments each cycle without `mem_ready`.
  - When it reaches `TIMEOUT`: drop the strobe, skip any remaining transaction, go to DONE with `resp_err`=1.
  - `resp_rdata` is not updated on abort.
- Not defined: no counter; the FSM waits indefinitely and `resp_err` is constant 0.

## Test plan
- Fill-only: addr 0x0000010, memory returns 0xDEADBEEF… after 10 cycles -> `mem_read` high exactly 11 cycles, `mem_addr`=0x0000010, `resp_valid` one pulse with that data, `mem_write` never high.
- WB+fill: wb_addr 0x0000020, data 0x1234…, fill_addr 0x0000030 -> `mem_write` phase, then exactly one all-low GAP cycle, then `mem_read` phase. Memory line 0x20 holds 0x1234…; one `resp_valid`.
- WB-only: wb_addr 0x0000040 -> a single `mem_write` transaction, `resp_valid` the cycle after `mem_ready`, `resp_rdata` unchanged.
- No-op plus back-to-back: a no-op request, then an immediate fill -> first `resp_valid` at T+1, second request accepted at T+2, no strobe from the first.
- Reset mid-FILL: assert `rst_n`=0 five cycles into a read -> `mem_read`=0 and `resp_valid`=0 asynchronously; after release, `req_ready`=1 and no stale response appears.
- With `MEM_TIMEOUT_EN`, `TIMEOUT`=8, memory never ready -> strobe drops after 8 wait cycles, `resp_valid` and `resp_err`=1 together, then IDLE.

Source files
------------

// File: rtl/mem_line_master.sv
// ---------------------------------------------------------------------------
// mem_line_master
//   Initiator side of the 128-bit line-transfer protocol toward the slow
//   memory model. Converts one cache miss request (optional dirty writeback
//   followed by an optional line fill) into strobe-and-hold mem_write /
//   mem_read transactions. Each transaction is held until mem_ready. The
//   request completes with a one-cycle resp_valid pulse.
//
//   Optional feature macro: MEM_TIMEOUT_EN
//     defined     : each transaction is abandoned after TIMEOUT cycles
//                   without mem_ready. The response then carries resp_err=1.
//     not defined : the FSM waits forever and o_resp_err is tied low.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req_valid         miss request from the cache
//   o_req_ready         high only while idle
//   i_req_wb/i_req_fill writeback / fill required
//   i_req_wb_addr       victim line address [31:4]
//   i_req_fill_addr     fill line address [31:4]
//   i_req_wdata         victim line data
//   o_resp_valid        one-cycle completion pulse
//   o_resp_rdata        last filled line, held until the next fill
//   o_resp_err          completion was a timeout abort
//   o_mem_read          read strobe toward memory
//   o_mem_write         write strobe toward memory
//   o_mem_addr          line address toward memory
//   o_mem_wdata         write line data
//   i_mem_rdata         read line data, valid with i_mem_ready
//   i_mem_ready         single-cycle completion pulse from memory
// ---------------------------------------------------------------------------
module mem_line_master #(
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_req_valid,
  output logic         o_req_ready,
  input  logic         i_req_wb,
  input  logic         i_req_fill,
  input  logic [27:0]  i_req_wb_addr,
  input  logic [27:0]  i_req_fill_addr,
  input  logic [127:0] i_req_wdata,
  output logic         o_resp_valid,
  output logic [127:0] o_resp_rdata,
  output logic         o_resp_err,
  output logic         o_mem_read,
  output logic         o_mem_write,
  output logic [27:0]  o_mem_addr,
  output logic [127:0] o_mem_wdata,
  input  logic [127:0] i_mem_rdata,
  input  logic         i_mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WB   = 3'd1,
    S_GAP  = 3'd2,
    S_FILL = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           r_fill;
  logic [27:0]    r_fill_addr;
  logic [27:0]    r_mem_addr;
  logic [127:0]   r_mem_wdata;
  logic [127:0]   r_resp_rdata;
  logic           w_accept;
  logic           w_waiting;
  logic           w_timeout;

  assign w_accept  = i_req_valid && (r_state == S_IDLE);
  // A transaction is outstanding while a strobe is up.
  assign w_waiting = (r_state == S_WB) || (r_state == S_FILL);

`ifdef MEM_TIMEOUT_EN
  localparam logic [10:0] TO_LAST = 11'(TIMEOUT - 1);

  logic [10:0] r_wait_cnt;
  logic        r_err;

  // The counter sits at zero whenever no strobe is up, so it is already
  // clear on entry to WB or FILL. The counter value is the number of
  // cycles already spent waiting. The cycle with value TIMEOUT-1 is the
  // last one allowed.
  assign w_timeout = w_waiting && !i_mem_ready && (r_wait_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_waiting && !i_mem_ready && !w_timeout) begin
        r_wait_cnt <= r_wait_cnt + 11'd1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_resp_err = (r_state == S_DONE) && r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
  assign o_resp_err       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    w_next       = r_state;
    o_req_ready  = 1'b0;
    o_resp_valid = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_read   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          if (i_req_wb)        w_next = S_WB;
          else if (i_req_fill) w_next = S_FILL;
          else                 w_next = S_DONE;
        end
      end
      S_WB: begin
        o_mem_write = 1'b1;
        if (w_timeout)        w_next = S_DONE;   // pending fill is skipped
        else if (i_mem_ready) w_next = r_fill ? S_GAP : S_DONE;
      end
      S_GAP: begin
        w_next = S_FILL;
      end
      S_FILL: begin
        o_mem_read = 1'b1;
        if (w_timeout || i_mem_ready) w_next = S_DONE;
      end
      S_DONE: begin
        o_resp_valid = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture and memory-side datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill       <= 1'b0;
      r_fill_addr  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_resp_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_fill      <= i_req_fill;
        r_fill_addr <= i_req_fill_addr;
        if (i_req_wb) begin
          r_mem_addr  <= i_req_wb_addr;
          r_mem_wdata <= i_req_wdata;
        end else if (i_req_fill) begin
          r_mem_addr  <= i_req_fill_addr;
        end
      end
      // Switch the address during the all-low gap so that it is stable
      // before the read strobe rises.
      if (r_state == S_GAP) begin
        r_mem_addr <= r_fill_addr;
      end
      if ((r_state == S_FILL) && i_mem_ready && !w_timeout) begin
        r_resp_rdata <= i_mem_rdata;
      end
    end
  end

  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_resp_rdata = r_resp_rdata;

endmodule
